// File: rtl/iotdf_sched.sv
// Round-robin frame scheduler sharing one IOTDF datapath among NREQ requesters.
// Each frame is 16 bytes in and one 128-bit result out, with a timeout on the result.
module iotdf_sched #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned TMO  = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [3*NREQ-1:0]   req_fn,
    input  logic [8*NREQ-1:0]   src_byte,
    output logic [NREQ-1:0]     gnt,
    output logic [3:0]          byte_idx,
    input  logic                dp_busy,
    input  logic                dp_valid,
    input  logic [127:0]        dp_out,
    output logic                dp_in_en,
    output logic [7:0]          dp_in,
    output logic [2:0]          dp_fn,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [127:0]        res_data,
    output logic [1:0]          res_id,
    output logic                res_err
);

    // Requester index width is fixed by the 2-bit res_id port.
    localparam int unsigned IDW   = 2;
    localparam int unsigned WCW   = (TMO > 1) ? $clog2(TMO) : 1;
    localparam int unsigned NBYTE = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_FEED,
        S_WAIT,
        S_RESULT
    } state_t;

    state_t           state, state_d;
    logic [IDW-1:0]   rr_ptr, rr_ptr_d;
    logic [IDW-1:0]   cur_id, cur_id_d;
    logic [WCW-1:0]   wcnt, wcnt_d;
    logic [NREQ-1:0]  gnt_d;
    logic [3:0]       byte_idx_d;
    logic [2:0]       dp_fn_d;
    logic             res_valid_d;
    logic [127:0]     res_data_d;
    logic [1:0]       res_id_d;
    logic             res_err_d;

    logic [2:0]       fn_lane   [NREQ];
    logic [7:0]       byte_lane [NREQ];

    logic             pick_found;
    logic [IDW-1:0]   pick_id;
    logic [IDW-1:0]   idx;

    // Unpack the flat per-requester buses into lanes.
    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        assign fn_lane[i]   = req_fn[3*i +: 3];
        assign byte_lane[i] = src_byte[8*i +: 8];
    end

    // Byte strobe follows dp_busy in the same cycle so no byte is lost or repeated.
    assign dp_in_en = (state == S_FEED) && !dp_busy;
    assign dp_in    = (state == S_FEED) ? byte_lane[cur_id] : 8'h00;

    // First set request at or after rr_ptr, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        idx        = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = IDW'((32'(rr_ptr) + k) % NREQ);
            if (!pick_found && req[idx]) begin
                pick_found = 1'b1;
                pick_id    = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            cur_id    <= '0;
            wcnt      <= '0;
            gnt       <= '0;
            byte_idx  <= '0;
            dp_fn     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
            res_err   <= 1'b0;
        end else begin
            state     <= state_d;
            rr_ptr    <= rr_ptr_d;
            cur_id    <= cur_id_d;
            wcnt      <= wcnt_d;
            gnt       <= gnt_d;
            byte_idx  <= byte_idx_d;
            dp_fn     <= dp_fn_d;
            res_valid <= res_valid_d;
            res_data  <= res_data_d;
            res_id    <= res_id_d;
            res_err   <= res_err_d;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state;
        rr_ptr_d    = rr_ptr;
        cur_id_d    = cur_id;
        wcnt_d      = wcnt;
        gnt_d       = gnt;
        byte_idx_d  = byte_idx;
        dp_fn_d     = dp_fn;
        res_valid_d = res_valid;
        res_data_d  = res_data;
        res_id_d    = res_id;
        res_err_d   = res_err;

        unique case (state)
            S_IDLE: begin
                if (|req) begin
                    state_d = S_ARB;
                end
            end
            S_ARB: begin
                if (pick_found) begin
                    cur_id_d        = pick_id;
                    gnt_d           = '0;
                    gnt_d[pick_id]  = 1'b1;
                    dp_fn_d         = fn_lane[pick_id];
                    rr_ptr_d        = IDW'((32'(pick_id) + 32'd1) % NREQ);
                    byte_idx_d      = '0;
                    state_d         = S_FEED;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FEED: begin
                if (!dp_busy) begin
                    if (byte_idx == 4'(NBYTE - 1)) begin
                        byte_idx_d = '0;
                        wcnt_d     = '0;
                        state_d    = S_WAIT;
                    end else begin
                        byte_idx_d = byte_idx + 4'd1;
                    end
                end
            end
            S_WAIT: begin
                if (dp_valid) begin
                    res_data_d  = dp_out;
                    res_err_d   = 1'b0;
                    res_id_d    = cur_id;
                    res_valid_d = 1'b1;
                    state_d     = S_RESULT;
                end else if (wcnt == WCW'(TMO - 1)) begin
                    res_data_d  = '0;
                    res_err_d   = 1'b1;
                    res_id_d    = cur_id;
                    res_valid_d = 1'b1;
                    state_d     = S_RESULT;
                end else begin
                    wcnt_d = wcnt + WCW'(1);
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    gnt_d       = '0;
                    dp_fn_d     = '0;
                    wcnt_d      = '0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_iotdf_sched.sv
// Directed bench for iotdf_sched: arbitration order, byte feeding with stalls,
// result capture, timeout, result back-pressure and mid-frame reset.
module tb_iotdf_sched;

    localparam int unsigned NREQ = 4;
    localparam int unsigned TMO  = 64;

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [3*NREQ-1:0]   req_fn;
    logic [8*NREQ-1:0]   src_byte;
    logic [NREQ-1:0]     gnt;
    logic [3:0]          byte_idx;
    logic                dp_busy;
    logic                dp_valid;
    logic [127:0]        dp_out;
    logic                dp_in_en;
    logic [7:0]          dp_in;
    logic [2:0]          dp_fn;
    logic                res_valid;
    logic                res_ready;
    logic [127:0]        res_data;
    logic [1:0]          res_id;
    logic                res_err;

    int errors = 0;
    int checks = 0;

    iotdf_sched #(.NREQ(NREQ), .TMO(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_fn    (req_fn),
        .src_byte  (src_byte),
        .gnt       (gnt),
        .byte_idx  (byte_idx),
        .dp_busy   (dp_busy),
        .dp_valid  (dp_valid),
        .dp_out    (dp_out),
        .dp_in_en  (dp_in_en),
        .dp_in     (dp_in),
        .dp_fn     (dp_fn),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_err   (res_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lane i sources byte 16*i + byte_idx; lane i function is i+1.
    assign req_fn = {3'd4, 3'd3, 3'd2, 3'd1};
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            src_byte[8*i +: 8] = 8'(16*i) + {4'h0, byte_idx};
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_gnt(output int n);
        n = 0;
        while (gnt == '0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("gnt_arrives", 128'(n < 10), 128'(1));
    endtask

    // Runs one FEED phase from its first cycle; returns on the first WAIT cycle.
    task automatic feed_frame(input int id, input int busy_at, input int busy_len);
        int pulses;
        int stalls;
        int cyc;
        pulses = 0;
        stalls = 0;
        cyc    = 0;
        while (pulses < 16 && cyc < 100) begin
            dp_busy = (stalls < busy_len) && (int'(byte_idx) == busy_at);
            #1;
            if (dp_busy) begin
                chk("busy_in_en", 128'(dp_in_en), 128'(0));
                chk("busy_hold_idx", 128'(byte_idx), 128'(busy_at));
                stalls++;
            end else begin
                chk("in_en", 128'(dp_in_en), 128'(1));
                chk("dp_in", 128'(dp_in), 128'(8'(16*id + pulses)));
                pulses++;
            end
            @(negedge clk);
            cyc++;
        end
        dp_busy = 1'b0;
        chk("pulse_count", 128'(pulses), 128'(16));
        chk("stall_count", 128'(stalls), 128'(busy_len));
        chk("idx_wrap", 128'(byte_idx), 128'(0));
    endtask

    initial begin
        int n;
        int exp_id;
        logic [127:0] exp_data;

        rst       = 1'b0;
        req       = '0;
        dp_busy   = 1'b0;
        dp_valid  = 1'b0;
        dp_out    = '0;
        res_ready = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        chk("rst_gnt", 128'(gnt), 128'(0));
        chk("rst_byte_idx", 128'(byte_idx), 128'(0));
        chk("rst_in_en", 128'(dp_in_en), 128'(0));
        chk("rst_dp_in", 128'(dp_in), 128'(0));
        chk("rst_dp_fn", 128'(dp_fn), 128'(0));
        chk("rst_res_valid", 128'(res_valid), 128'(0));
        chk("rst_res_data", res_data, 128'(0));
        chk("rst_res_id", 128'(res_id), 128'(0));
        chk("rst_res_err", 128'(res_err), 128'(0));
        @(negedge clk);
        rst = 1'b1;

        // Stray dp_valid in IDLE is ignored
        dp_valid = 1'b1;
        dp_out   = {16{8'h55}};
        repeat (2) @(negedge clk);
        #1;
        chk("idle_valid_ignored", 128'(res_valid), 128'(0));
        chk("idle_no_gnt", 128'(gnt), 128'(0));
        dp_valid = 1'b0;

        // Basic frame on requester 0, result 3 cycles after last byte
        @(negedge clk);
        req = 4'b0001;
        @(negedge clk);
        #1 chk("arb_cycle_gnt", 128'(gnt), 128'(0));
        @(negedge clk);
        #1;
        chk("f1_gnt", 128'(gnt), 128'(4'b0001));
        chk("f1_fn", 128'(dp_fn), 128'(3'b001));
        chk("f1_idx0", 128'(byte_idx), 128'(0));
        req = '0;
        feed_frame(0, 99, 0);
        #1;
        chk("f1_wait1_rv", 128'(res_valid), 128'(0));
        chk("f1_wait_gnt", 128'(gnt), 128'(4'b0001));
        @(negedge clk);
        #1 chk("f1_wait2_rv", 128'(res_valid), 128'(0));
        @(negedge clk);
        dp_valid = 1'b1;
        dp_out   = {16{8'hAB}};
        @(negedge clk);
        dp_valid = 1'b0;
        dp_out   = '0;
        #1;
        chk("f1_res_valid", 128'(res_valid), 128'(1));
        chk("f1_res_data", res_data, {16{8'hAB}});
        chk("f1_res_id", 128'(res_id), 128'(0));
        chk("f1_res_err", 128'(res_err), 128'(0));
        chk("f1_res_fn", 128'(dp_fn), 128'(3'b001));
        @(negedge clk);
        #1;
        chk("f1_res_hold", res_data, {16{8'hAB}});
        chk("f1_rv_hold", 128'(res_valid), 128'(1));
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        chk("f1_handoff_rv", 128'(res_valid), 128'(0));
        chk("f1_handoff_gnt", 128'(gnt), 128'(0));
        chk("f1_handoff_fn", 128'(dp_fn), 128'(0));

        // Reset returns rr_ptr to 0, then round-robin with all requesting
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        req       = 4'b1111;
        res_ready = 1'b1;
        for (int f = 0; f < 5; f++) begin
            exp_id   = f % 4;
            exp_data = {16{8'(8'hC0 + exp_id)}};
            wait_gnt(n);
            #1;
            chk("rr_gnt", 128'(gnt), 128'(4'b0001 << exp_id));
            chk("rr_fn", 128'(dp_fn), 128'(exp_id + 1));
            feed_frame(exp_id, 99, 0);
            dp_valid = 1'b1;
            dp_out   = exp_data;
            @(negedge clk);
            dp_valid = 1'b0;
            if (f == 4) req = '0;
            #1;
            chk("rr_res_valid", 128'(res_valid), 128'(1));
            chk("rr_res_id", 128'(res_id), 128'(exp_id));
            chk("rr_res_data", res_data, exp_data);
            @(negedge clk);
            #1 chk("rr_released", 128'(gnt), 128'(0));
        end
        res_ready = 1'b0;

        // Busy stall on byte 5 for 4 cycles (rr_ptr=1, only requester 2 asks)
        req = 4'b0100;
        wait_gnt(n);
        #1 chk("busy_gnt", 128'(gnt), 128'(4'b0100));
        req = '0;
        feed_frame(2, 5, 4);
        req = 4'b0010;
        @(negedge clk);
        dp_valid = 1'b1;
        dp_out   = {8{16'hBEEF}};
        @(negedge clk);
        dp_valid = 1'b0;
        dp_out   = '0;

        // Result held under back-pressure with another request pending
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("bp_res_valid", 128'(res_valid), 128'(1));
            chk("bp_res_data", res_data, {8{16'hBEEF}});
            chk("bp_res_id", 128'(res_id), 128'(2));
            chk("bp_gnt", 128'(gnt), 128'(4'b0100));
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        chk("bp_handoff_gnt", 128'(gnt), 128'(0));
        chk("bp_handoff_rv", 128'(res_valid), 128'(0));
        @(negedge clk);
        #1 chk("bp_arb_gnt", 128'(gnt), 128'(0));
        @(negedge clk);
        #1 chk("bp_next_gnt", 128'(gnt), 128'(4'b0010));

        // Timeout frame; dp_valid during FEED must be ignored
        req      = '0;
        dp_valid = 1'b1;
        dp_out   = {16{8'hFF}};
        feed_frame(1, 99, 0);
        dp_valid = 1'b0;
        dp_out   = '0;
        n = 0;
        while (!res_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk("tmo_cycles", 128'(n), 128'(TMO));
        chk("tmo_res_err", 128'(res_err), 128'(1));
        chk("tmo_res_data", res_data, 128'(0));
        chk("tmo_res_id", 128'(res_id), 128'(1));
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        #1 chk("tmo_handoff_gnt", 128'(gnt), 128'(0));

        // Reset in the middle of a frame at byte 8
        req = 4'b1000;
        wait_gnt(n);
        #1 chk("mr_gnt", 128'(gnt), 128'(4'b1000));
        n = 0;
        while (byte_idx != 4'd8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("mr_reach8", 128'(byte_idx), 128'(8));
        rst = 1'b0;
        #1;
        chk("mr_gnt0", 128'(gnt), 128'(0));
        chk("mr_idx0", 128'(byte_idx), 128'(0));
        chk("mr_in_en0", 128'(dp_in_en), 128'(0));
        chk("mr_dp_in0", 128'(dp_in), 128'(0));
        chk("mr_fn0", 128'(dp_fn), 128'(0));
        chk("mr_rv0", 128'(res_valid), 128'(0));
        chk("mr_id0", 128'(res_id), 128'(0));
        chk("mr_err0", 128'(res_err), 128'(0));
        @(negedge clk);
        rst = 1'b1;
        wait_gnt(n);
        #1;
        chk("mr_regrant", 128'(gnt), 128'(4'b1000));
        chk("mr_restart_idx", 128'(byte_idx), 128'(0));
        chk("mr_regrant_fn", 128'(dp_fn), 128'(3'b100));
        req = '0;
        feed_frame(3, 99, 0);
        dp_valid = 1'b1;
        dp_out   = {4{32'h1234_5678}};
        @(negedge clk);
        dp_valid = 1'b0;
        #1;
        chk("mr_res_valid", 128'(res_valid), 128'(1));
        chk("mr_res_id", 128'(res_id), 128'(3));
        chk("mr_res_data", res_data, {4{32'h1234_5678}});
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        #1 chk("mr_handoff_gnt", 128'(gnt), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/iotdf_sched.md
IOTDF_SCHED -- requirements
Module: iotdf_sched

Interface
REQ-001 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-002 Parameter NREQ, 4, number of requesters sharing one IOTDF datapath.
REQ-003 Parameter TMO, 64, max cycles waited for datapath valid after last byte.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 req  in  NREQ  per-requester frame request, level, held until gnt.
REQ-007 req_fn  in  3*NREQ  per-requester function select, lane i = bits [3i+2:3i].
REQ-008 src_byte  in  8*NREQ  per-requester byte lane; lane i must show byte byte_idx combinationally while gnt[i]=1.
REQ-009 gnt  out  NREQ  one-hot grant, high from ARB exit until result handed off.
REQ-010 byte_idx  out  4  index of byte currently offered, 0 = first byte.
REQ-011 dp_busy  in  1  datapath busy.
REQ-012 dp_valid  in  1  datapath result strobe.
REQ-013 dp_out  in  128  datapath result.
REQ-014 dp_in_en  out  1  byte strobe to datapath.
REQ-015 dp_in  out  8  byte to datapath.
REQ-016 dp_fn  out  3  function select to datapath.
REQ-017 res_valid  out  1  result available.
REQ-018 res_ready  in  1  consumer accepts result.
REQ-019 res_data  out  128  captured result, zero on error.
REQ-020 res_id  out  2  index of requester owning the result.
REQ-021 res_err  out  1  result ended in timeout.

Function
REQ-022 States SHALL be IDLE, ARB, FEED, WAIT, RESULT; one frame in flight at a time.
REQ-023 IDLE -> ARB when any req bit high; otherwise stay IDLE, gnt=0.
REQ-024 ARB SHALL pick first set req at or after rr_ptr (wrapping NREQ-1 -> 0), latch its id and fn, assert gnt next cycle, go FEED; ARB lasts exactly one cycle.
REQ-025 rr_ptr SHALL become granted id+1 mod NREQ on each grant; reset value 0.
REQ-026 dp_fn SHALL equal latched fn from grant until RESULT exits; 0 in IDLE.
REQ-027 FEED: each cycle dp_busy=0, dp_in_en=1 and dp_in=src_byte lane[id]; byte_idx increments after each such cycle.
REQ-028 FEED: cycle with dp_busy=1 SHALL drive dp_in_en=0, hold byte_idx; no byte dropped or repeated.
REQ-029 After byte_idx 15 accepted, byte_idx wraps to 0 and FSM goes WAIT.
REQ-030 WAIT: wait counter counts from 0 each cycle; dp_valid=1 captures dp_out into res_data, res_err=0, go RESULT.
REQ-031 WAIT: counter reaching TMO-1 without dp_valid SHALL set res_err=1, res_data=0, go RESULT.
REQ-032 dp_valid outside WAIT SHALL be ignored.
REQ-033 RESULT: res_valid=1, res_data/res_id/res_err stable until res_ready=1; on that cycle gnt drops, FSM -> IDLE (next grant earliest 2 cycles later).
REQ-034 req changing during FEED/WAIT/RESULT SHALL not affect current frame; gnt holder dropping req mid-frame does not abort it.
REQ-035 Frame latency (no busy stalls, dp_valid k cycles after last byte) = 1 ARB + 16 FEED + k WAIT cycles to res_valid.

Reset
REQ-036 rst low SHALL asynchronously force IDLE, rr_ptr=0, byte_idx=0, gnt=0, dp_in_en=0, dp_in=0, dp_fn=0, res_valid=0, res_data=0, res_id=0, res_err=0, wait counter 0.
REQ-037 rst low mid-frame SHALL abandon frame with no result; first grant after release follows rr_ptr=0.

Verification
REQ-038 req=0001, fn0=001, bytes 0x00..0x0F, dp_busy=0, dp_valid 3 cycles after last byte with 0xAB..AB -> gnt=0001, 16 in_en pulses dp_in 0x00..0x0F, dp_fn=001, res_valid with res_id=0, res_data=0xAB..AB, res_err=0.
REQ-039 req=1111 held, res_ready=1 -> grant order 0,1,2,3,0; each frame exactly 16 dp_in_en pulses.
REQ-040 dp_busy high on byte_idx 5 for 4 cycles -> dp_in_en low those cycles, byte 5 sent once after busy drops, total 16 bytes.
REQ-041 dp_valid never asserted -> res_valid after TMO cycles in WAIT, res_err=1, res_data=0.
REQ-042 res_ready=0 for 10 cycles in RESULT with req=0010 pending -> outputs stable, gnt held, no new grant until handoff.
REQ-043 rst low at byte_idx 8 -> all outputs reset immediately; after release, req=1000 -> gnt=1000, byte_idx restarts at 0.
